bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared data bus. Takes bus requests from N sources and grants

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_arbiter_rr_priority_enc.sv | 38 +++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encodings and default sizes.
// The default requester count equals the mux_array MUX_DATA_WIDTH default so
// that sel lines up with the mux select input S.
package bus_arbiter_pkg;

    localparam int MUX_DATA_WIDTH_DEFAULT = 4;
    localparam int ARB_N_REQ_DEFAULT      = MUX_DATA_WIDTH_DEFAULT;
    localparam int ARB_MAX_HOLD_DEFAULT   = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_priority_enc.sv
// Combinational round-robin priority encoder.
// Scans req starting at last_ptr+1 and wrapping modulo N_REQ; bits set in
// exclude are ignored. found is high when any candidate exists and idx is
// the first candidate in scan order.
module rr_priority_enc
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ_DEFAULT,
    parameter int SEL_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [SEL_WIDTH-1:0] last_ptr,
    input  logic [N_REQ-1:0]     exclude,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    logic [N_REQ-1:0]     cand;
    logic [SEL_WIDTH-1:0] pos;

    assign cand = req & ~exclude;

    // Walk offsets from farthest to nearest so the nearest candidate is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            // N_REQ is a power of two, so truncating the sum gives the modulo wrap.
            pos = last_ptr + SEL_WIDTH'(off);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and binary sel for
// the downstream mux_array. Ownership is held until the owner drops its
// request; handoff to the next waiting requester happens in the same edge.
// Optional feature macro ARB_TIMEOUT_EN: forces a handoff (and pulses
// timeout) once an owner has held the bus MAX_HOLD cycles while others wait.
// Handshake: req[i] is a level request; grant[i] high means requester i owns
// the bus for that cycle; a requester releases by dropping req[i].
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ_DEFAULT,
    parameter int SEL_WIDTH = $clog2(N_REQ),
    parameter int MAX_HOLD  = ARB_MAX_HOLD_DEFAULT,
    parameter int CNT_WIDTH = $clog2(MAX_HOLD) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     grant,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 bus_busy,
    output logic                 timeout,
    output arb_state_t           state_dbg,
    output logic [CNT_WIDTH-1:0] hold_dbg
);

    arb_state_t           state_q, state_d;
    logic [SEL_WIDTH-1:0] last_ptr_q, last_ptr_d;
    logic [N_REQ-1:0]     grant_d;
    logic [SEL_WIDTH-1:0] sel_d;
    logic [N_REQ-1:0]     exclude;
    logic                 enc_found;
    logic [SEL_WIDTH-1:0] enc_idx;
    logic                 owner_req;
    logic                 take;

    // While owned, last_ptr is the owner: exclude it so a handoff never re-picks it.
    assign exclude   = (state_q == ARB_OWNED) ? (N_REQ'(1) << last_ptr_q) : '0;
    assign owner_req = req[last_ptr_q];

    rr_priority_enc #(
        .N_REQ     (N_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_enc (
        .req      (req),
        .last_ptr (last_ptr_q),
        .exclude  (exclude),
        .found    (enc_found),
        .idx      (enc_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] hold_q;
    logic                 hold_at_limit;
    logic                 force_handoff;
    logic                 timeout_q;

    assign hold_at_limit = (hold_q >= CNT_WIDTH'(MAX_HOLD - 1));
`endif

    // State and grant/sel/pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            grant      <= '0;
            sel        <= '0;
            last_ptr_q <= SEL_WIDTH'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            sel        <= sel_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    // Next state: leave IDLE on any request; return to IDLE only when the owner releases and nobody waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (enc_found) state_d = ARB_OWNED;
            ARB_OWNED: if (!owner_req && !enc_found) state_d = ARB_IDLE;
        endcase
    end

    // Next grant/sel/pointer: take a new winner on fresh arbitration, release-handoff or forced handoff.
    always_comb begin
        grant_d    = grant;
        sel_d      = sel;
        last_ptr_d = last_ptr_q;
        take       = 1'b0;
`ifdef ARB_TIMEOUT_EN
        force_handoff = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                take    = enc_found;
            end
            ARB_OWNED: begin
                if (!owner_req) begin
                    if (enc_found) take = 1'b1;
                    else           grant_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_at_limit && enc_found) begin
                    take          = 1'b1;
                    force_handoff = 1'b1;
                end
`endif
            end
        endcase
        if (take) begin
            grant_d    = N_REQ'(1) << enc_idx;
            sel_d      = enc_idx;
            last_ptr_d = enc_idx;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: restarts on each new owner, counts owned cycles and saturates at MAX_HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_handoff;
            if (take)
                hold_q <= '0;
            else if (state_q == ARB_OWNED && hold_q != CNT_WIDTH'(MAX_HOLD))
                hold_q <= hold_q + 1'b1;
        end
    end

    assign timeout  = timeout_q;
    assign hold_dbg = hold_q;
`else
    assign timeout  = 1'b0;
    assign hold_dbg = '0;
`endif

    assign bus_busy  = |grant;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_REQ=4, MAX_HOLD=8). Each step drives req
// at a falling edge and queues the expected {grant, sel, bus_busy, timeout}
// for just after the next rising edge; an independent monitor pops and compares.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int EW = N + SW + 2;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [SW-1:0] sel;
  logic          bus_busy;
  logic          timeout;
  arb_state_t    state_dbg;
  logic [CW-1:0] hold_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.N_REQ(N), .SEL_WIDTH(SW), .MAX_HOLD(8), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .bus_busy  (bus_busy),
    .timeout   (timeout),
    .state_dbg (state_dbg),
    .hold_dbg  (hold_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pack_exp(logic [N-1:0] g, logic [SW-1:0] s, logic t);
    return {g, s, (g != '0), t};
  endfunction

  task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
               name, act[EW-1 -: N], act[3:2], act[1], act[0],
               exp[EW-1 -: N], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // monitor: compare registered outputs just after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("step", {grant, sel, bus_busy, timeout}, e);
    end
  end

  // driver tasks
  task automatic step(logic [N-1:0] r, logic [N-1:0] g, logic [SW-1:0] s, logic t);
    @(negedge clk);
    req = r;
    exp_q.push_back(pack_exp(g, s, t));
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_dut();
    drain();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;

    // 1. reset holds everything clear even with all requests high
    repeat (2) @(posedge clk);
    #1;
    check("reset", {grant, sel, bus_busy, timeout}, pack_exp(4'b0000, 2'd0, 1'b0));
    @(negedge clk);
    req     = '0;
    reset_n = 1'b1;

    // 2. fresh grant then release-handoff without an idle cycle
    step(4'b0101, 4'b0001, 2'd0, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);

    // 3. fairness: order 0,1,2,3,0,1
    reset_dut();
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0010, 2'd1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b1101, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1011, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b0);
    step(4'b0111, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);

    // 4. wrap: owner 2 -> 3 -> 0
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1011, 4'b1000, 2'd3, 1'b0);
    step(4'b0011, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 5. long hold with a competitor, then a lone owner
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
`ifdef ARB_TIMEOUT_EN
      if (k <= 8)       step(4'b0011, 4'b0001, 2'd0, 1'b0);
      else if (k == 9)  step(4'b0011, 4'b0010, 2'd1, 1'b1);
      else              step(4'b0011, 4'b0010, 2'd1, 1'b0);
`else
      step(4'b0011, 4'b0001, 2'd0, 1'b0);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
`else
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
`endif
    for (int k = 1; k <= 12; k++) step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 6. async reset mid-ownership, then priority restarts at 0
    reset_dut();
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    drain();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", {grant, sel, bus_busy, timeout}, pack_exp(4'b0000, 2'd0, 1'b0));
    req = 4'b0110;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(pack_exp(4'b0010, 2'd1, 1'b0));
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
